// File: rtl/ibex_pkg.sv
// ============================================================================
//  Module   : ibex_pkg
//  Purpose  : Shared types for the writeback queue: the instruction class
//             enum and the fixed-width queue entry record.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    logic [31:0]    pc;
    logic           compressed;
    logic           perf_count;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    logic           we;
    logic           done;
    logic           err;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/ibex_wb_queue_if.sv
// ============================================================================
//  Module   : ibex_wb_queue_if
//  Purpose  : Bundles the ID/EX hand-off, LSU response and writeback outputs
//             of the writeback queue.
//  Ports    : master - ID/EX + LSU side (drives requests, sees status)
//             slave  - the queue itself
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ibex_wb_queue_if;
  import ibex_pkg::*;

  logic           en_wb_i;
  wb_instr_type_e instr_type_wb_i;
  logic [31:0]    pc_id_i;
  logic           instr_is_compressed_id_i;
  logic           instr_perf_count_id_i;
  logic [4:0]     rf_waddr_id_i;
  logic [31:0]    rf_wdata_id_i;
  logic           rf_we_id_i;
  logic           lsu_resp_valid_i;
  logic           lsu_resp_err_i;
  logic [31:0]    rf_wdata_lsu_i;

  logic           ready_wb_o;
  logic [31:0]    rf_pending_wb_o;
  logic           outstanding_load_wb_o;
  logic           outstanding_store_wb_o;
  logic [31:0]    pc_wb_o;
  logic           instr_done_wb_o;
  logic           perf_instr_ret_wb_o;
  logic           perf_instr_ret_compressed_wb_o;
  logic [4:0]     rf_waddr_wb_o;
  logic [31:0]    rf_wdata_wb_o;
  logic           rf_we_wb_o;
  logic [4:0]     rf_waddr_fwd_wb_o;
  logic [31:0]    rf_wdata_fwd_wb_o;
  logic           rf_we_fwd_wb_o;

  modport master (
    output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
           instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
    input  ready_wb_o, rf_pending_wb_o, outstanding_load_wb_o,
           outstanding_store_wb_o, pc_wb_o, instr_done_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o,
           rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
           rf_waddr_fwd_wb_o, rf_wdata_fwd_wb_o, rf_we_fwd_wb_o
  );

  modport slave (
    input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
           instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
    output ready_wb_o, rf_pending_wb_o, outstanding_load_wb_o,
           outstanding_store_wb_o, pc_wb_o, instr_done_wb_o,
           perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o,
           rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o,
           rf_waddr_fwd_wb_o, rf_wdata_fwd_wb_o, rf_we_fwd_wb_o
  );

endinterface

`default_nettype wire

// File: rtl/ibex_wb_queue.sv
// ============================================================================
//  Module   : ibex_wb_queue
//  Purpose  : In-order writeback queue of WbDepth entries. Instructions are
//             enqueued from ID/EX, LOAD/STORE entries wait for their LSU
//             response, the head retires and writes the register file.
//  Ports    : clk_i  - clock
//             rst_ni - asynchronous active-low reset
//             wb     - ibex_wb_queue_if.slave (requests, responses, outputs)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int unsigned WbDepth = 2,
  parameter bit          WbFwdEn = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ibex_wb_queue_if.slave wb
);

  localparam int unsigned     PtrW    = (WbDepth > 1) ? $clog2(WbDepth) : 1;
  localparam int unsigned     CntW    = $clog2(WbDepth + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(WbDepth - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  wb_entry_t        r_entries [WbDepth];
  logic [WbDepth-1:0] r_valid;
  logic [PtrW-1:0]  r_head;
  logic [PtrW-1:0]  r_tail;
  logic [CntW-1:0]  r_count;

  logic             w_resp_found;
  logic [PtrW-1:0]  w_resp_idx;
  logic             w_resp_tgt;
  logic             w_hit_head;
  logic             w_head_valid;
  wb_entry_t        w_head;
  logic             w_head_err;
  logic             w_done;
  logic             w_ready;
  logic             w_enq;
  logic [31:0]      w_pending;
  logic             w_out_load;
  logic             w_out_store;

  // Walk from the head in age order; the first unfinished memory entry
  // owns the incoming LSU response.
  always_comb begin
    logic [PtrW-1:0] idx;
    w_resp_found = 1'b0;
    w_resp_idx   = r_head;
    idx          = r_head;
    for (int k = 0; k < WbDepth; k++) begin
      if (!w_resp_found && r_valid[idx] && !r_entries[idx].done &&
          r_entries[idx].instr_type != WB_INSTR_OTHER) begin
        w_resp_found = 1'b1;
        w_resp_idx   = idx;
      end
      idx = ptr_inc(idx);
    end
  end

  assign w_resp_tgt   = wb.lsu_resp_valid_i & w_resp_found;
  assign w_head_valid = r_valid[r_head];
  assign w_head       = r_entries[r_head];
  assign w_hit_head   = w_resp_tgt & (w_resp_idx == r_head);
  assign w_head_err   = w_head.err | (w_hit_head & wb.lsu_resp_err_i);
  assign w_done       = w_head_valid & (w_head.done | w_hit_head);
  assign w_ready      = (r_count < CntW'(WbDepth)) | w_done;
  assign w_enq        = wb.en_wb_i & w_ready;

  // Payload fields are deliberately left out of the reset branch; only the
  // control flags are cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < WbDepth; i++) begin
        r_entries[i].done <= 1'b0;
        r_entries[i].err  <= 1'b0;
      end
    end else begin
      if (w_resp_tgt) begin
        r_entries[w_resp_idx].done <= 1'b1;
        r_entries[w_resp_idx].err  <= wb.lsu_resp_err_i;
        if (r_entries[w_resp_idx].instr_type == WB_INSTR_LOAD) begin
          r_entries[w_resp_idx].wdata <= wb.rf_wdata_lsu_i;
        end
      end
      if (w_done) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      // Enqueue last: at full with a retire the tail slot is the slot the
      // head is vacating, and the new entry must win.
      if (w_enq) begin
        r_entries[r_tail] <= '{instr_type: wb.instr_type_wb_i,
                               pc:         wb.pc_id_i,
                               compressed: wb.instr_is_compressed_id_i,
                               perf_count: wb.instr_perf_count_id_i,
                               waddr:      wb.rf_waddr_id_i,
                               wdata:      wb.rf_wdata_id_i,
                               we:         wb.rf_we_id_i,
                               done:       (wb.instr_type_wb_i == WB_INSTR_OTHER),
                               err:        1'b0};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= ptr_inc(r_tail);
      end
      case ({w_enq, w_done})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_pending   = '0;
    w_out_load  = 1'b0;
    w_out_store = 1'b0;
    for (int i = 0; i < WbDepth; i++) begin
      if (r_valid[i]) begin
        if (r_entries[i].we || r_entries[i].instr_type == WB_INSTR_LOAD) begin
          w_pending[r_entries[i].waddr] = 1'b1;
        end
        if (!r_entries[i].done) begin
          w_out_load  = w_out_load  | (r_entries[i].instr_type == WB_INSTR_LOAD);
          w_out_store = w_out_store | (r_entries[i].instr_type == WB_INSTR_STORE);
        end
      end
    end
    w_pending[0] = 1'b0;  // x0 is hard-wired zero, never a hazard
  end

  assign wb.ready_wb_o             = w_ready;
  assign wb.rf_pending_wb_o        = w_pending;
  assign wb.outstanding_load_wb_o  = w_out_load;
  assign wb.outstanding_store_wb_o = w_out_store;
  assign wb.pc_wb_o                = w_head_valid ? w_head.pc : 32'd0;
  assign wb.instr_done_wb_o        = w_done;
  assign wb.perf_instr_ret_wb_o    = w_done & w_head.perf_count & ~w_head_err;
  assign wb.perf_instr_ret_compressed_wb_o =
      w_done & w_head.perf_count & ~w_head_err & w_head.compressed;
  assign wb.rf_we_wb_o    = w_done & ~w_head_err &
                            (((w_head.instr_type == WB_INSTR_OTHER) & w_head.we) |
                             (w_head.instr_type == WB_INSTR_LOAD));
  assign wb.rf_waddr_wb_o = w_head_valid ? w_head.waddr : 5'd0;
  assign wb.rf_wdata_wb_o = !w_head_valid ? 32'd0 :
                            w_hit_head    ? wb.rf_wdata_lsu_i : w_head.wdata;

  generate
    if (WbFwdEn) begin : g_fwd
      logic [PtrW-1:0] w_young;
      logic            w_fwd_we;
      // Youngest entry sits just behind the tail pointer.
      assign w_young  = (r_tail == '0) ? LastIdx : r_tail - 1'b1;
      assign w_fwd_we = r_valid[w_young] &
                        (r_entries[w_young].instr_type == WB_INSTR_OTHER) &
                        r_entries[w_young].we;
      assign wb.rf_we_fwd_wb_o    = w_fwd_we;
      assign wb.rf_waddr_fwd_wb_o = w_fwd_we ? r_entries[w_young].waddr : 5'd0;
      assign wb.rf_wdata_fwd_wb_o = w_fwd_we ? r_entries[w_young].wdata : 32'd0;
    end else begin : g_no_fwd
      assign wb.rf_we_fwd_wb_o    = 1'b0;
      assign wb.rf_waddr_fwd_wb_o = 5'd0;
      assign wb.rf_wdata_fwd_wb_o = 32'd0;
    end
  endgenerate

  a_enq_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.en_wb_i |-> w_ready)
    else $error("ibex_wb_queue: en_wb_i asserted while queue not ready");

  a_resp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
      wb.lsu_resp_valid_i |-> w_resp_found)
    else $error("ibex_wb_queue: LSU response with no pending memory entry");

endmodule

`default_nettype wire

// File: tb/tb_ibex_wb_queue.sv
// ============================================================================
//  Module   : tb_ibex_wb_queue
//  Purpose  : Directed bench for ibex_wb_queue at WbDepth=2 and WbDepth=3.
//             Register-file writes are checked by scoreboard monitors; status
//             outputs are checked inline against hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ibex_wb_queue;
  import ibex_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ibex_wb_queue_if if2 ();
  ibex_wb_queue_if if3 ();

  ibex_wb_queue #(.WbDepth(2), .WbFwdEn(1'b1)) dut2 (.clk_i(clk), .rst_ni(rst_n), .wb(if2));
  ibex_wb_queue #(.WbDepth(3), .WbFwdEn(1'b1)) dut3 (.clk_i(clk), .rst_ni(rst_n), .wb(if3));

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp2[$];
  wr_t exp3[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every RF write pops the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && if2.rf_we_wb_o === 1'b1) begin
      if (exp2.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut2_unexpected_write: got x%0d=0x%0h expected none",
                 if2.rf_waddr_wb_o, if2.rf_wdata_wb_o);
      end else begin
        e = exp2.pop_front();
        chk("dut2_wr_addr", 32'(if2.rf_waddr_wb_o), 32'(e.a));
        chk("dut2_wr_data", if2.rf_wdata_wb_o, e.d);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && if3.rf_we_wb_o === 1'b1) begin
      if (exp3.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dut3_unexpected_write: got x%0d=0x%0h expected none",
                 if3.rf_waddr_wb_o, if3.rf_wdata_wb_o);
      end else begin
        e = exp3.pop_front();
        chk("dut3_wr_addr", 32'(if3.rf_waddr_wb_o), 32'(e.a));
        chk("dut3_wr_data", if3.rf_wdata_wb_o, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr2();
    if2.en_wb_i = 1'b0; if2.instr_type_wb_i = WB_INSTR_OTHER; if2.pc_id_i = '0;
    if2.instr_is_compressed_id_i = 1'b0; if2.instr_perf_count_id_i = 1'b0;
    if2.rf_waddr_id_i = '0; if2.rf_wdata_id_i = '0; if2.rf_we_id_i = 1'b0;
    if2.lsu_resp_valid_i = 1'b0; if2.lsu_resp_err_i = 1'b0; if2.rf_wdata_lsu_i = '0;
  endtask

  task automatic clr3();
    if3.en_wb_i = 1'b0; if3.instr_type_wb_i = WB_INSTR_OTHER; if3.pc_id_i = '0;
    if3.instr_is_compressed_id_i = 1'b0; if3.instr_perf_count_id_i = 1'b0;
    if3.rf_waddr_id_i = '0; if3.rf_wdata_id_i = '0; if3.rf_we_id_i = 1'b0;
    if3.lsu_resp_valid_i = 1'b0; if3.lsu_resp_err_i = 1'b0; if3.rf_wdata_lsu_i = '0;
  endtask

  task automatic enq2(input wb_instr_type_e t, input logic [4:0] a, input logic [31:0] d,
                      input logic we, input logic [31:0] pc, input logic comp);
    if2.en_wb_i = 1'b1; if2.instr_type_wb_i = t; if2.rf_waddr_id_i = a;
    if2.rf_wdata_id_i = d; if2.rf_we_id_i = we; if2.pc_id_i = pc;
    if2.instr_is_compressed_id_i = comp; if2.instr_perf_count_id_i = 1'b1;
  endtask

  task automatic resp2(input logic [31:0] d, input logic err);
    if2.lsu_resp_valid_i = 1'b1; if2.rf_wdata_lsu_i = d; if2.lsu_resp_err_i = err;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int enq_i;
    int resp_i;
    int mcnt;
    clr2(); clr3();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready",   32'(if2.ready_wb_o), 32'd1);
    chk("rst_pending", if2.rf_pending_wb_o, 32'd0);
    chk("rst_done",    32'(if2.instr_done_wb_o), 32'd0);
    chk("rst_we",      32'(if2.rf_we_wb_o), 32'd0);
    chk("rst_pc",      if2.pc_wb_o, 32'd0);
    chk("rst_ready3",  32'(if3.ready_wb_o), 32'd1);
    rst_n = 1'b1;

    // Back-to-back OTHER instructions
    tick(); clr2(); enq2(WB_INSTR_OTHER, 5'd5, 32'h1234, 1'b1, 32'h80, 1'b1);
    exp2.push_back('{a: 5'd5, d: 32'h1234});
    #1 chk("a_ready0", 32'(if2.ready_wb_o), 32'd1);
    tick(); clr2(); enq2(WB_INSTR_OTHER, 5'd6, 32'h5678, 1'b1, 32'h84, 1'b0);
    exp2.push_back('{a: 5'd6, d: 32'h5678});
    #1;
    chk("a_ready1",  32'(if2.ready_wb_o), 32'd1);
    chk("a_done1",   32'(if2.instr_done_wb_o), 32'd1);
    chk("a_pc1",     if2.pc_wb_o, 32'h80);
    chk("a_perf1",   32'(if2.perf_instr_ret_wb_o), 32'd1);
    chk("a_perfc1",  32'(if2.perf_instr_ret_compressed_wb_o), 32'd1);
    chk("a_fwd_we",  32'(if2.rf_we_fwd_wb_o), 32'd1);
    chk("a_fwd_adr", 32'(if2.rf_waddr_fwd_wb_o), 32'd5);
    chk("a_fwd_dat", if2.rf_wdata_fwd_wb_o, 32'h1234);
    tick(); clr2(); #1;
    chk("a_ready2", 32'(if2.ready_wb_o), 32'd1);
    chk("a_pc2",    if2.pc_wb_o, 32'h84);
    chk("a_perfc2", 32'(if2.perf_instr_ret_compressed_wb_o), 32'd0);
    tick(); clr2(); #1;
    chk("a_idle", 32'(if2.instr_done_wb_o), 32'd0);

    // LOAD blocks a younger OTHER until its response
    tick(); clr2(); enq2(WB_INSTR_LOAD, 5'd7, 32'd0, 1'b0, 32'h90, 1'b0);
    exp2.push_back('{a: 5'd7, d: 32'hDEAD});
    tick(); clr2(); enq2(WB_INSTR_OTHER, 5'd8, 32'h88, 1'b1, 32'h94, 1'b0);
    exp2.push_back('{a: 5'd8, d: 32'h88});
    #1 chk("b_fwd_load", 32'(if2.rf_we_fwd_wb_o), 32'd0);
    tick(); clr2(); #1;
    chk("b_ready_full", 32'(if2.ready_wb_o), 32'd0);
    chk("b_pending",    if2.rf_pending_wb_o, 32'h180);
    chk("b_out_load",   32'(if2.outstanding_load_wb_o), 32'd1);
    chk("b_no_done",    32'(if2.instr_done_wb_o), 32'd0);
    tick(); clr2(); resp2(32'hDEAD, 1'b0); #1;
    chk("b_done",  32'(if2.instr_done_wb_o), 32'd1);
    chk("b_ready", 32'(if2.ready_wb_o), 32'd1);
    tick(); clr2(); #1;
    chk("b_done8",   32'(if2.instr_done_wb_o), 32'd1);
    chk("b_no_load", 32'(if2.outstanding_load_wb_o), 32'd0);

    // STORE then LOAD, responses attributed in order
    tick(); clr2(); enq2(WB_INSTR_STORE, 5'd3, 32'h3333, 1'b0, 32'hA0, 1'b0);
    tick(); clr2(); enq2(WB_INSTR_LOAD, 5'd9, 32'd0, 1'b0, 32'hA4, 1'b0);
    exp2.push_back('{a: 5'd9, d: 32'h9999});
    #1 chk("c_out_store", 32'(if2.outstanding_store_wb_o), 32'd1);
    tick(); clr2(); resp2(32'h1111, 1'b0); #1;
    chk("c_st_done", 32'(if2.instr_done_wb_o), 32'd1);
    chk("c_st_nowe", 32'(if2.rf_we_wb_o), 32'd0);
    chk("c_st_pc",   if2.pc_wb_o, 32'hA0);
    tick(); clr2(); resp2(32'h9999, 1'b0); #1;
    chk("c_ld_done", 32'(if2.instr_done_wb_o), 32'd1);
    chk("c_ld_we",   32'(if2.rf_we_wb_o), 32'd1);
    chk("c_ld_pc",   if2.pc_wb_o, 32'hA4);

    // LOAD with bus error
    tick(); clr2(); enq2(WB_INSTR_LOAD, 5'd10, 32'd0, 1'b0, 32'hB0, 1'b0);
    tick(); clr2(); resp2(32'hBAD, 1'b1); #1;
    chk("d_pending", if2.rf_pending_wb_o, 32'h400);
    chk("d_done",    32'(if2.instr_done_wb_o), 32'd1);
    chk("d_nowe",    32'(if2.rf_we_wb_o), 32'd0);
    chk("d_noperf",  32'(if2.perf_instr_ret_wb_o), 32'd0);
    tick(); clr2(); #1;
    chk("d_idle", 32'(if2.instr_done_wb_o), 32'd0);

    // Reset with two entries valid and a response in flight
    tick(); clr2(); enq2(WB_INSTR_LOAD, 5'd11, 32'd0, 1'b0, 32'hC0, 1'b0);
    tick(); clr2(); enq2(WB_INSTR_LOAD, 5'd12, 32'd0, 1'b0, 32'hC4, 1'b0);
    tick(); clr2(); #1;
    chk("e_pending_pre", if2.rf_pending_wb_o, 32'h1800);
    chk("e_ready_pre",   32'(if2.ready_wb_o), 32'd0);
    rst_n = 1'b0;
    resp2(32'h77, 1'b0);
    #1;
    chk("e_rst_ready",   32'(if2.ready_wb_o), 32'd1);
    chk("e_rst_done",    32'(if2.instr_done_wb_o), 32'd0);
    chk("e_rst_we",      32'(if2.rf_we_wb_o), 32'd0);
    chk("e_rst_pending", if2.rf_pending_wb_o, 32'd0);
    chk("e_rst_outld",   32'(if2.outstanding_load_wb_o), 32'd0);
    chk("e_rst_pc",      if2.pc_wb_o, 32'd0);
    tick(); clr2(); rst_n = 1'b1; #1;
    chk("e_post_done",    32'(if2.instr_done_wb_o), 32'd0);
    chk("e_post_pending", if2.rf_pending_wb_o, 32'd0);
    tick(); clr2(); #1;
    chk("e_post_ready", 32'(if2.ready_wb_o), 32'd1);

    // WbDepth=3: ten LOADs, responses every other cycle, pointers wrap
    enq_i = 0; resp_i = 0; mcnt = 0;
    for (int cyc = 0; cyc < 60 && (enq_i < 10 || mcnt > 0); cyc++) begin
      bit do_resp;
      bit do_enq;
      bit ready_m;
      tick(); clr3();
      do_resp = (mcnt > 0) && (cyc >= 4) && (cyc % 2 == 0);
      ready_m = (mcnt < 3) || do_resp;
      do_enq  = ready_m && (enq_i < 10);
      if (do_resp) begin
        if3.lsu_resp_valid_i = 1'b1;
        if3.rf_wdata_lsu_i   = 32'hA000 + 32'(resp_i);
      end
      if (do_enq) begin
        if3.en_wb_i = 1'b1; if3.instr_type_wb_i = WB_INSTR_LOAD;
        if3.rf_waddr_id_i = 5'(enq_i + 1); if3.pc_id_i = 32'h200 + 32'(4 * enq_i);
        exp3.push_back('{a: 5'(enq_i + 1), d: 32'hA000 + 32'(enq_i)});
      end
      #1;
      chk("f_ready",    32'(if3.ready_wb_o), 32'(ready_m));
      chk("f_out_load", 32'(if3.outstanding_load_wb_o), 32'(mcnt > 0));
      if (do_resp) begin resp_i++; mcnt--; end
      if (do_enq)  begin enq_i++;  mcnt++; end
    end
    tick(); clr3();

    for (int w = 0; w < 10 && (exp2.size() != 0 || exp3.size() != 0); w++) tick();
    chk("drain_exp2", 32'(exp2.size()), 32'd0);
    chk("drain_exp3", 32'(exp3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
